// File: rtl/gpio_pkg.sv
// Shared constants and helpers for the wb_gpio Wishbone GPIO block.
package gpio_pkg;

    localparam int GPIO_MAX_WIDTH = 32;
    localparam int GPIO_DEB_CNT_W = 8;

    localparam logic [2:0] GPIO_REG_IN   = 3'd0;
    localparam logic [2:0] GPIO_REG_OUT  = 3'd1;
    localparam logic [2:0] GPIO_REG_MASK = 3'd2;
    localparam logic [2:0] GPIO_REG_EDGE = 3'd3;
    localparam logic [2:0] GPIO_REG_PEND = 3'd4;

    // Width of a counter that must hold 0..(clkFreq/1000 - 1).
    function automatic int prescWidth(input int clkFreq);
        int period;
        period = clkFreq / 1000;
        return (period <= 2) ? 1 : $clog2(period);
    endfunction

    function automatic logic [GPIO_MAX_WIDTH-1:0] laneMask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One GPIO input bit: 2-flop synchroniser followed by an optional tick-based
// debouncer (present only when GPIO_DEBOUNCE_EN is defined).
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int debounce_ms = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_level
);

    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic [GPIO_DEB_CNT_W-1:0] r_cnt;
    logic                      r_level;

    // Any tick where the synchronised value still agrees with the accepted
    // level restarts the count, so a glitch never accumulates across windows.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (r_sync2 == r_level) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            if (r_cnt == GPIO_DEB_CNT_W'(debounce_ms - 1)) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + GPIO_DEB_CNT_W'(1);
            end
        end
    end

    assign o_level = r_level;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = i_tick ^ (debounce_ms == 0);
    assign o_level      = r_sync2;
`endif

endmodule

// File: rtl/wb_gpio.sv
// Wishbone GPIO slave: debounced inputs, OUT/MASK/EDGE/PEND registers and a
// registered level interrupt. Debounce/prescaler built only with GPIO_DEBOUNCE_EN.
module wb_gpio
    import gpio_pkg::*;
#(
    parameter int clk_freq    = 50000000,
    parameter int debounce_ms = 5,
    parameter int in_width    = 12,
    parameter int out_width   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          wb_adr_i,
    input  logic [31:0]          wb_dat_i,
    output logic [31:0]          wb_dat_o,
    input  logic [3:0]           wb_sel_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_we_i,
    output logic                 wb_ack_o,
    input  logic [in_width-1:0]  gpio_in,
    output logic [out_width-1:0] gpio_out,
    output logic                 intr
);

    logic w_tick;

`ifdef GPIO_DEBOUNCE_EN
    localparam int PERIOD  = clk_freq / 1000;
    localparam int PRESC_W = prescWidth(clk_freq);

    logic [PRESC_W-1:0] r_presc;

    assign w_tick = (r_presc == PRESC_W'(PERIOD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (clk_freq == 0);
    assign w_tick       = 1'b0;
`endif

    logic [in_width-1:0] w_level;

    for (genvar g = 0; g < in_width; g++) begin : g_in
        gpio_debounce #(
            .debounce_ms(debounce_ms)
        ) u_deb (
            .clk    (clk),
            .reset  (reset),
            .i_tick (w_tick),
            .i_raw  (gpio_in[g]),
            .o_level(w_level[g])
        );
    end

    logic [out_width-1:0] r_out;
    logic [in_width-1:0]  r_mask;
    logic [in_width-1:0]  r_edge;
    logic [in_width-1:0]  r_pend;
    logic [in_width-1:0]  r_level_d;
    logic                 r_ack;
    logic [31:0]          r_dat;
    logic                 r_intr;

    logic                 w_access;
    logic                 w_write;
    logic [2:0]           w_idx;
    logic [31:0]          w_lane;
    logic [in_width-1:0]  w_wr_in;
    logic [out_width-1:0] w_wr_out;
    logic [in_width-1:0]  w_edge;
    logic [in_width-1:0]  w_clr;
    logic [31:0]          w_rdata;
    logic                 w_unused_bus;

    assign w_access = wb_stb_i & wb_cyc_i & ~r_ack;
    assign w_write  = w_access & wb_we_i;
    assign w_idx    = wb_adr_i[4:2];
    assign w_lane   = laneMask(wb_sel_i);
    assign w_wr_in  = w_lane[in_width-1:0];
    assign w_wr_out = w_lane[out_width-1:0];
    assign w_edge   = (w_level & ~r_level_d & ~r_edge) | (~w_level & r_level_d & r_edge);
    assign w_clr    = (w_write && w_idx == GPIO_REG_PEND) ? (wb_dat_i[in_width-1:0] & w_wr_in) : '0;

    assign w_unused_bus = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i, w_lane};

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            GPIO_REG_IN:   w_rdata = 32'(w_level);
            GPIO_REG_OUT:  w_rdata = 32'(r_out);
            GPIO_REG_MASK: w_rdata = 32'(r_mask);
            GPIO_REG_EDGE: w_rdata = 32'(r_edge);
            GPIO_REG_PEND: w_rdata = 32'(r_pend);
            default:       w_rdata = '0;
        endcase
    end

    // Writes and read data both land on the edge that raises ack; a new
    // edge event outranks a simultaneous W1C of the same PEND bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out     <= '0;
            r_mask    <= '0;
            r_edge    <= '0;
            r_pend    <= '0;
            r_level_d <= '0;
            r_ack     <= 1'b0;
            r_dat     <= '0;
            r_intr    <= 1'b0;
        end else begin
            r_ack     <= w_access;
            r_dat     <= (w_access & ~wb_we_i) ? w_rdata : '0;
            r_level_d <= w_level;
            r_pend    <= (r_pend & ~w_clr) | w_edge;
            r_intr    <= |(r_pend & r_mask);
            if (w_write) begin
                case (w_idx)
                    GPIO_REG_OUT:  r_out  <= (r_out & ~w_wr_out) | (wb_dat_i[out_width-1:0] & w_wr_out);
                    GPIO_REG_MASK: r_mask <= (r_mask & ~w_wr_in) | (wb_dat_i[in_width-1:0] & w_wr_in);
                    GPIO_REG_EDGE: r_edge <= (r_edge & ~w_wr_in) | (wb_dat_i[in_width-1:0] & w_wr_in);
                    default: ;
                endcase
            end
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign gpio_out = r_out;
    assign intr     = r_intr;

endmodule

// File: tb/tb_wb_gpio.sv
// Self-checking bench for wb_gpio: table-driven register accesses with a read
// scoreboard, plus hand-written edge, interrupt, back-to-back and reset sequences.
module tb_wb_gpio;
    import gpio_pkg::*;

    localparam int IW = 12;
    localparam int OW = 8;
`ifdef GPIO_DEBOUNCE_EN
    localparam int SETTLE = 40;
    localparam int LAT_LO = 20;
    localparam int LAT_HI = 24;
`else
    localparam int SETTLE = 6;
    localparam int LAT_LO = 4;
    localparam int LAT_HI = 4;
`endif
    localparam int NVEC = 26;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   wb_adr_i;
    logic [31:0]   wb_dat_i;
    logic [31:0]   wb_dat_o;
    logic [3:0]    wb_sel_i;
    logic          wb_stb_i;
    logic          wb_cyc_i;
    logic          wb_we_i;
    logic          wb_ack_o;
    logic [IW-1:0] gpio_in;
    logic [OW-1:0] gpio_out;
    logic          intr;

    int checks   = 0;
    int failures = 0;
    logic [31:0] expQ[$];

    typedef struct {
        logic        we;
        logic [2:0]  idx;
        logic [3:0]  sel;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[NVEC];

    always #5 clk = ~clk;

    wb_gpio #(
        .clk_freq   (4000),
        .debounce_ms(5),
        .in_width   (IW),
        .out_width  (OW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wb_adr_i(wb_adr_i),
        .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o),
        .wb_sel_i(wb_sel_i),
        .wb_stb_i(wb_stb_i),
        .wb_cyc_i(wb_cyc_i),
        .wb_we_i (wb_we_i),
        .wb_ack_o(wb_ack_o),
        .gpio_in (gpio_in),
        .gpio_out(gpio_out),
        .intr    (intr)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One Wishbone access; returns at the negedge where ack was seen.
    task automatic applyStimulus(input logic we, input logic [2:0] idx, input logic [3:0] sel,
                                 input logic [31:0] data, input logic [31:0] exp, input string name);
        int lat;
        logic [31:0] want;
        @(negedge clk);
        wb_adr_i = 32'hF002_0000 | (32'(idx) << 2);
        wb_dat_i = data;
        wb_sel_i = sel;
        wb_we_i  = we;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        if (!we) expQ.push_back(exp);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (wb_ack_o !== 1'b1 && lat < 8);
        checkOutput({name, " ack latency"}, 32'(lat), 32'd1);
        if (!we) begin
            want = expQ.pop_front();
            if (wb_ack_o === 1'b1) checkOutput(name, wb_dat_o, want);
        end
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic waitIntr(input string name, input int lo, input int hi);
        int lat;
        lat = 0;
        while (intr !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (intr !== 1'b1 || lat < lo || lat > hi) begin
            failures++;
            $display("[TB] FAIL %s: intr high after %0d cycles (intr=%b), required %0d..%0d",
                     name, lat, intr, lo, hi);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_sel_i = '0;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
        gpio_in  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset ack", 32'(wb_ack_o), 32'd0);
        checkOutput("reset dat_o", wb_dat_o, 32'd0);
        checkOutput("reset gpio_out", 32'(gpio_out), 32'd0);
        checkOutput("reset intr", 32'(intr), 32'd0);

        vecs[0]  = '{1'b0, GPIO_REG_IN,   4'hF, 32'h0,         32'h0};
        vecs[1]  = '{1'b0, GPIO_REG_OUT,  4'hF, 32'h0,         32'h0};
        vecs[2]  = '{1'b0, GPIO_REG_MASK, 4'hF, 32'h0,         32'h0};
        vecs[3]  = '{1'b0, GPIO_REG_EDGE, 4'hF, 32'h0,         32'h0};
        vecs[4]  = '{1'b0, GPIO_REG_PEND, 4'hF, 32'h0,         32'h0};
        vecs[5]  = '{1'b1, GPIO_REG_OUT,  4'h1, 32'h0000_00A5, 32'h0};
        vecs[6]  = '{1'b0, GPIO_REG_OUT,  4'hF, 32'h0,         32'h0000_00A5};
        vecs[7]  = '{1'b1, GPIO_REG_OUT,  4'h2, 32'h1234_5678, 32'h0};
        vecs[8]  = '{1'b0, GPIO_REG_OUT,  4'hF, 32'h0,         32'h0000_00A5};
        vecs[9]  = '{1'b1, GPIO_REG_MASK, 4'h2, 32'hFFFF_FFFF, 32'h0};
        vecs[10] = '{1'b0, GPIO_REG_MASK, 4'hF, 32'h0,         32'h0000_0F00};
        vecs[11] = '{1'b1, GPIO_REG_MASK, 4'hF, 32'hFFFF_FFFF, 32'h0};
        vecs[12] = '{1'b0, GPIO_REG_MASK, 4'hF, 32'h0,         32'h0000_0FFF};
        vecs[13] = '{1'b1, GPIO_REG_MASK, 4'hF, 32'h0,         32'h0};
        vecs[14] = '{1'b0, GPIO_REG_MASK, 4'hF, 32'h0,         32'h0};
        vecs[15] = '{1'b1, GPIO_REG_EDGE, 4'h5, 32'h0F0F_0F0F, 32'h0};
        vecs[16] = '{1'b0, GPIO_REG_EDGE, 4'hF, 32'h0,         32'h0000_000F};
        vecs[17] = '{1'b1, GPIO_REG_EDGE, 4'hF, 32'h0,         32'h0};
        vecs[18] = '{1'b1, 3'd5,          4'hF, 32'hFFFF_FFFF, 32'h0};
        vecs[19] = '{1'b0, 3'd5,          4'hF, 32'h0,         32'h0};
        vecs[20] = '{1'b0, 3'd6,          4'hF, 32'h0,         32'h0};
        vecs[21] = '{1'b0, 3'd7,          4'hF, 32'h0,         32'h0};
        vecs[22] = '{1'b1, GPIO_REG_IN,   4'hF, 32'h0000_0FFF, 32'h0};
        vecs[23] = '{1'b0, GPIO_REG_IN,   4'hF, 32'h0,         32'h0};
        vecs[24] = '{1'b1, GPIO_REG_PEND, 4'hF, 32'h0000_0FFF, 32'h0};
        vecs[25] = '{1'b0, GPIO_REG_PEND, 4'hF, 32'h0,         32'h0};

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].we, vecs[i].idx, vecs[i].sel, vecs[i].data, vecs[i].exp,
                          $sformatf("vec%0d", i));
        end
        checkOutput("gpio_out after OUT writes", 32'(gpio_out), 32'h0000_00A5);
        checkOutput("intr idle", 32'(intr), 32'd0);

        // Rising edge on bit 3 with its interrupt enabled: full input-to-intr latency.
        applyStimulus(1'b1, GPIO_REG_MASK, 4'hF, 32'h008, 32'h0, "mask bit3");
        @(negedge clk);
        gpio_in[3] = 1'b1;
        waitIntr("bit3 rise to intr", LAT_LO, LAT_HI);
        applyStimulus(1'b0, GPIO_REG_IN,   4'hF, 32'h0, 32'h008, "IN after bit3");
        applyStimulus(1'b0, GPIO_REG_PEND, 4'hF, 32'h0, 32'h008, "PEND after bit3");
        applyStimulus(1'b1, GPIO_REG_PEND, 4'h1, 32'h008, 32'h0, "W1C bit3");
        checkOutput("intr at W1C ack", 32'(intr), 32'd1);
        @(negedge clk);
        checkOutput("intr after W1C", 32'(intr), 32'd0);

        // PEND sets on an unmasked bit; enabling the mask raises intr one cycle later.
        gpio_in[0] = 1'b1;
        repeat (SETTLE) @(negedge clk);
        applyStimulus(1'b0, GPIO_REG_PEND, 4'hF, 32'h0, 32'h001, "PEND unmasked bit0");
        checkOutput("intr with bit0 masked", 32'(intr), 32'd0);
        applyStimulus(1'b1, GPIO_REG_MASK, 4'hF, 32'h009, 32'h0, "mask bit0");
        checkOutput("intr at mask ack", 32'(intr), 32'd0);
        @(negedge clk);
        checkOutput("intr after mask", 32'(intr), 32'd1);
        applyStimulus(1'b1, GPIO_REG_PEND, 4'h1, 32'h001, 32'h0, "W1C bit0");

        // Falling-edge selection on bit 1.
        applyStimulus(1'b1, GPIO_REG_EDGE, 4'hF, 32'h002, 32'h0, "edge bit1 fall");
        applyStimulus(1'b1, GPIO_REG_MASK, 4'hF, 32'h002, 32'h0, "mask bit1");
        gpio_in[1] = 1'b1;
        repeat (SETTLE) @(negedge clk);
        applyStimulus(1'b0, GPIO_REG_PEND, 4'hF, 32'h0, 32'h000, "PEND bit1 rise ignored");
        checkOutput("intr on bit1 rise", 32'(intr), 32'd0);
        gpio_in[1] = 1'b0;
        repeat (SETTLE) @(negedge clk);
        applyStimulus(1'b0, GPIO_REG_PEND, 4'hF, 32'h0, 32'h002, "PEND bit1 fall");
        checkOutput("intr on bit1 fall", 32'(intr), 32'd1);
        applyStimulus(1'b1, GPIO_REG_PEND, 4'h1, 32'h002, 32'h0, "W1C bit1");
        checkOutput("intr at bit1 W1C ack", 32'(intr), 32'd1);
        @(negedge clk);
        checkOutput("intr after bit1 W1C", 32'(intr), 32'd0);
        applyStimulus(1'b0, GPIO_REG_PEND, 4'hF, 32'h0, 32'h000, "PEND after bit1 W1C");
        applyStimulus(1'b1, GPIO_REG_EDGE, 4'hF, 32'h000, 32'h0, "edge restore");

        // Short pulse on bit 4: rejected by the debouncer, seen by the bare synchroniser.
        @(negedge clk);
        gpio_in[4] = 1'b1;
`ifdef GPIO_DEBOUNCE_EN
        repeat (3) @(negedge clk);
        gpio_in[4] = 1'b0;
        repeat (SETTLE) @(negedge clk);
        applyStimulus(1'b0, GPIO_REG_IN,   4'hF, 32'h0, 32'h009, "IN after glitch");
        applyStimulus(1'b0, GPIO_REG_PEND, 4'hF, 32'h0, 32'h000, "PEND after glitch");
`else
        @(negedge clk);
        gpio_in[4] = 1'b0;
        repeat (SETTLE) @(negedge clk);
        applyStimulus(1'b0, GPIO_REG_IN,   4'hF, 32'h0, 32'h009, "IN after pulse");
        applyStimulus(1'b0, GPIO_REG_PEND, 4'hF, 32'h0, 32'h010, "PEND after pulse");
        applyStimulus(1'b1, GPIO_REG_PEND, 4'h1, 32'h010, 32'h0, "W1C bit4");

        // Edge on bit 2 lands on the same clock edge as its W1C: the set must survive.
        @(negedge clk);
        gpio_in[2] = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, GPIO_REG_PEND, 4'h1, 32'h004, 32'h0, "W1C race bit2");
        applyStimulus(1'b0, GPIO_REG_PEND, 4'hF, 32'h0, 32'h004, "PEND after race");
        applyStimulus(1'b1, GPIO_REG_PEND, 4'h1, 32'h004, 32'h0, "W1C bit2");
        applyStimulus(1'b0, GPIO_REG_PEND, 4'hF, 32'h0, 32'h000, "PEND after bit2 W1C");
`endif

        // Strobe held high: ack pulses every other cycle, dat_o is 0 between acks.
        @(negedge clk);
        wb_adr_i = 32'hF002_0000 | (32'(GPIO_REG_OUT) << 2);
        wb_sel_i = 4'hF;
        wb_we_i  = 1'b0;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        repeat (3) expQ.push_back(32'h0000_00A5);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checkOutput($sformatf("b2b ack cycle %0d", k), 32'(wb_ack_o), 32'(k % 2));
            if (k % 2 == 1) checkOutput($sformatf("b2b data cycle %0d", k), wb_dat_o, expQ.pop_front());
            else            checkOutput($sformatf("b2b idle data cycle %0d", k), wb_dat_o, 32'h0);
        end
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;

        // Reset asserted during a write: no ack, no commit, registers cleared.
        gpio_in = '0;
        repeat (SETTLE) @(negedge clk);
        @(negedge clk);
        wb_adr_i = 32'hF002_0000 | (32'(GPIO_REG_OUT) << 2);
        wb_dat_i = 32'h0000_00FF;
        wb_sel_i = 4'h1;
        wb_we_i  = 1'b1;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        reset    = 1'b1;
        @(negedge clk);
        checkOutput("ack under reset", 32'(wb_ack_o), 32'd0);
        checkOutput("gpio_out under reset", 32'(gpio_out), 32'd0);
        reset    = 1'b0;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
        applyStimulus(1'b0, GPIO_REG_OUT,  4'hF, 32'h0, 32'h0, "OUT after reset");
        applyStimulus(1'b0, GPIO_REG_MASK, 4'hF, 32'h0, 32'h0, "MASK after reset");
        checkOutput("intr after reset", 32'(intr), 32'd0);

        checkOutput("scoreboard empty", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_gpio.md
Name: wb_gpio

Overview:
- Wishbone slave for board-level GPIO. Inputs are the 4 buttons and 8 switches; outputs are the 8 LEDs.
- Plugs into conbus slave slot s5, at 0xF0020000.
- Synchronises and debounces inputs, exposes a software-writable output register, and raises one level interrupt on selected input edges.
- Interrupt line feeds the CPU interrupt_n vector (active-high here; inverted at top level, same as timer0).

Parameters:
- clk_freq, 50000000, system clock in Hz; prescaler period P = clk_freq/1000 cycles (1 ms tick).
- debounce_ms, 5, consecutive ms ticks an input must differ from its debounced value before the change is accepted; range 1..255.
- in_width, 12, number of inputs (1..32).
- out_width, 8, number of outputs (1..32).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wb_adr_i  in  32  Wishbone address; only bits [4:2] decoded.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_sel_i  in  4  byte-lane enables.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_we_i  in  1  write enable.
- wb_ack_o  out  1  acknowledge.
- gpio_in  in  in_width  raw asynchronous inputs ({sw, btn} at top level).
- gpio_out  out  out_width  OUT register contents.
- intr  out  1  interrupt, active-high, registered.

Behaviour:
- Reset: wb_ack_o=0, wb_dat_o=0, gpio_out=0, intr=0; OUT=0, MASK=0, EDGE=0, PEND=0; synchronisers, debounced state, counters and prescaler =0.
- Wishbone handshake:
  - wb_ack_o <= wb_stb_i & wb_cyc_i & ~wb_ack_o, giving a one-cycle pulse with 1 wait state.
  - Back-to-back accesses therefore complete every 2 cycles.
  - Reads: wb_dat_o registered on the same edge that raises ack; 0 otherwise.
  - Writes: committed on the edge that raises ack, per byte lane in wb_sel_i.
- Register map (word index = adr[4:2]):
  - 0 IN: RO, debounced inputs, upper bits 0.
  - 1 OUT: RW, drives gpio_out.
  - 2 MASK: RW, interrupt enable per input.
  - 3 EDGE: RW, per input: 0 = rising, 1 = falling.
  - 4 PEND: RO-W1C, edge-pending flags.
  - 5..7: read 0, writes ignored.
  - Bits >= in_width/out_width read 0; writes to them are ignored.
- Input path: 2-flop synchroniser per bit, then debounce.
- Prescaler: counts 0..P-1 and pulses tick at P-1, then wraps.
- Debounce, per bit:
  - Sync value equal to debounced value: counter cleared.
  - Else, on each tick counter increments; when it reaches debounce_ms the debounced value takes the sync value and the counter clears.
  - Glitch shorter than one tick window is never accepted.
  - Acceptance latency after a stable change: 2 + ((debounce_ms-1)*P .. debounce_ms*P) cycles.
- Edge detect: compare debounced value with its 1-cycle delayed copy; a selected-polarity change sets PEND bit on the next cycle.
  - PEND sets regardless of MASK.
- PEND set and W1C of the same bit in the same cycle: set wins.
- intr <= |(PEND & MASK), registered, so it asserts 1 cycle after PEND/MASK change.
- Reset mid-transaction: ack dropped next cycle, no write committed; master must restart.

Optional Feature:
- GPIO_DEBOUNCE_EN: when defined, the debounce logic and prescaler above are present.
- When undefined, the debounced value is the synchroniser output directly (latency 2 cycles) and debounce_ms/clk_freq are unused.
- Register map and interrupts are unchanged either way.

Decomposition:
- Package gpio_pkg:
  - register word indices: GPIO_REG_IN=0, OUT=1, MASK=2, EDGE=3, PEND=4.
  - constant GPIO_MAX_WIDTH=32.
  - function computing prescaler width from clk_freq.
- Sub-module gpio_debounce: one bit, holds synchroniser, counter and debounced output; instantiated in a generate loop sharing the top-level tick.

Test Plan:
- Reset → all Wishbone/OUT/MASK/EDGE/PEND reads 0, gpio_out=0, intr=0; write OUT=0xA5 with sel=4'b0001 → gpio_out=0xA5, ack exactly one cycle, 1 wait state.
- Byte lanes: clk_freq=4000 (P=4), debounce_ms=5; write MASK=0xFFFFFFFF with sel=4'b0010 → MASK reads 0x00000F00.
- Bounce: hold gpio_in[0] high → IN[0]=1 within 2+16..2+20 cycles; PEND=0x001 and intr=0 (MASK[0]=0).
  - Then set MASK=0x001 → intr=1 one cycle later.
  - Pulse gpio_in[1] high for 3 cycles → IN, PEND unchanged.
- Falling edge: EDGE=0x002, MASK=0x002; toggle gpio_in[1] 0→1→0 with stable windows → PEND[1] set only on fall; write PEND=0x002 → PEND=0, intr drops next cycle.
- Set/clear race: force debounced edge on bit 2 in same cycle as W1C of bit 2 → PEND[2]=1 afterwards.
- Without GPIO_DEBOUNCE_EN: gpio_in[3] 0→1 → IN[3]=1 after exactly 2 cycles; PEND[3]=1 one cycle after IN[3] changes.
